// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use, redirect,
// multi-cycle MUL/DIV and memory-wait hazards, with watchdog and stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned MULDIV_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEM_READ,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             EX_MULDIV_START,
    input  logic             MULDIV_DONE,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    output logic             PC_ENABLE,
    output logic             IF_ID_ENABLE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_ENABLE,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_ENABLE,
    output logic             EX_MEM_FLUSH,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic             MULDIV_ERR,
    output logic             STATE
);

    localparam int unsigned     WD_W   = $clog2(MULDIV_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MULDIV_TIMEOUT);

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [WD_W-1:0] watchdog;
    logic            load_use;
    logic            mdstall;

    always_comb begin
        load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                   ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                    (ID_USES_RS2 && (ID_RS2 == EX_RD)));
        mdstall  = !MULDIV_DONE && ((state == MULDIV_WAIT) || EX_MULDIV_START);
    end

    always_comb begin
        state_next    = state;
        PC_ENABLE     = 1'b1;
        IF_ID_ENABLE  = 1'b1;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_ENABLE  = 1'b1;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_ENABLE = 1'b1;
        EX_MEM_FLUSH  = 1'b0;

        // A stalled data access freezes the FSM too, so a DONE seen then is not consumed.
        if (!DMEM_BUSY) begin
            unique case (state)
                RUN:         if (EX_MULDIV_START && !MULDIV_DONE) state_next = MULDIV_WAIT;
                MULDIV_WAIT: if (MULDIV_DONE) state_next = RUN;
                default:     state_next = RUN;
            endcase
        end

        if (DMEM_BUSY) begin
            PC_ENABLE     = 1'b0;
            IF_ID_ENABLE  = 1'b0;
            ID_EX_ENABLE  = 1'b0;
            EX_MEM_ENABLE = 1'b0;
        end else if (mdstall) begin
            PC_ENABLE     = 1'b0;
            IF_ID_ENABLE  = 1'b0;
            ID_EX_ENABLE  = 1'b0;
            EX_MEM_FLUSH  = 1'b1;
        end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH   = 1'b1;
            ID_EX_FLUSH   = 1'b1;
        end else if (load_use) begin
            PC_ENABLE     = 1'b0;
            IF_ID_ENABLE  = 1'b0;
            ID_EX_FLUSH   = 1'b1;
        end else if (IMEM_BUSY) begin
            PC_ENABLE     = 1'b0;
            IF_ID_FLUSH   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= RUN;
            watchdog     <= '0;
            MULDIV_ERR   <= 1'b0;
            STALL_CYCLES <= '0;
        end else begin
            state <= state_next;

            if (state == RUN) begin
                watchdog <= '0;
            end else begin
                if (watchdog != WD_MAX) watchdog <= watchdog + WD_W'(1);
                // Flags on the cycle the count reaches the timeout.
                if (watchdog >= WD_MAX - WD_W'(1)) MULDIV_ERR <= 1'b1;
            end

            if (!PC_ENABLE && (STALL_CYCLES != '1))
                STALL_CYCLES <= STALL_CYCLES + CNT_W'(1);
        end
    end

    assign STATE = (state == MULDIV_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed checks of pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int CW  = 4;
    localparam int TO  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [4:0]    rs1, rs2, ex_rd;
    logic          u1, u2, mem_read, br, start, done, imem, dmem;
    logic          PC_ENABLE, IF_ID_ENABLE, IF_ID_FLUSH, ID_EX_ENABLE, ID_EX_FLUSH;
    logic          EX_MEM_ENABLE, EX_MEM_FLUSH, MULDIV_ERR, STATE;
    logic [CW-1:0] STALL_CYCLES;
    logic [6:0]    obs, exp;

    logic m_wait, m_err;
    int   m_wd, m_stall;
    int   n_vec = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl #(.CNT_W(CW), .MULDIV_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(rs1), .ID_RS2(rs2), .ID_USES_RS1(u1), .ID_USES_RS2(u2),
        .EX_RD(ex_rd), .EX_MEM_READ(mem_read), .EX_BRANCH_TAKEN(br),
        .EX_MULDIV_START(start), .MULDIV_DONE(done),
        .IMEM_BUSY(imem), .DMEM_BUSY(dmem),
        .PC_ENABLE(PC_ENABLE), .IF_ID_ENABLE(IF_ID_ENABLE), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_ENABLE(ID_EX_ENABLE), .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MEM_ENABLE(EX_MEM_ENABLE), .EX_MEM_FLUSH(EX_MEM_FLUSH),
        .STALL_CYCLES(STALL_CYCLES), .MULDIV_ERR(MULDIV_ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    assign obs = {PC_ENABLE, IF_ID_ENABLE, IF_ID_FLUSH, ID_EX_ENABLE, ID_EX_FLUSH,
                  EX_MEM_ENABLE, EX_MEM_FLUSH};

    // Expected controls, bit order {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl}.
    task automatic model_outputs(output logic [6:0] e);
        bit lu, md;
        lu = mem_read && ex_rd != 0 && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
        md = !done && (m_wait || start);
        if (dmem)      e = 7'b0000000;
        else if (md)   e = 7'b0000011;
        else if (br)   e = 7'b1111110;
        else if (lu)   e = 7'b0001110;
        else if (imem) e = 7'b0111010;
        else           e = 7'b1101010;
    endtask

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_wd = 0; m_stall = 0;
    endtask

    task automatic tick();
        logic [6:0] e;
        model_outputs(e);
        if (!e[6] && m_stall < CNT_MAX) m_stall++;
        if (m_wait) begin
            if (m_wd < TO) m_wd++;
            if (m_wd >= TO) m_err = 1;
        end else begin
            m_wd = 0;
        end
        if (!dmem) begin
            if (!m_wait && start && !done) m_wait = 1;
            else if (m_wait && done)       m_wait = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        rs1 = 0; rs2 = 0; ex_rd = 0; u1 = 0; u2 = 0; mem_read = 0;
        br = 0; start = 0; done = 0; imem = 0; dmem = 0;
    endtask

    task automatic do_reset();
        set_idle();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        RESET = 1'b1;
        #2;
        model_reset();
        model_outputs(exp);
        n_vec++;
        if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {7'b1101010, 1'b0, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset: got ctl=%b st=%b err=%b stall=%0d, exp ctl=1101010 st=0 err=0 stall=0",
                     obs, STATE, MULDIV_ERR, STALL_CYCLES);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            case (i)
                0: begin mem_read = 1; ex_rd = 5; rs2 = 5; u2 = 1; rs1 = 3; u1 = 1; end
                2: begin mem_read = 1; ex_rd = 0; rs2 = 0; u2 = 1; end
                3: begin mem_read = 1; ex_rd = 5; rs2 = 5; u2 = 1; br = 1; end
                4: imem = 1;
                default: ;
            endcase
            #3;
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL load_use cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            tick();
        end
        n_vec++;
        if (STALL_CYCLES !== 4'd2) begin
            n_err++;
            $display("FAIL load_use_stalls: got %0d, exp 2", STALL_CYCLES);
        end
    endtask

    task automatic test_muldiv();
        int st_cycles = 0;
        int bubbles   = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            start = (i < 4);
            done  = (i == 3);
            #3;
            st_cycles += int'(STATE);
            bubbles   += int'(EX_MEM_FLUSH);
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL muldiv cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            tick();
        end
        n_vec++;
        if (st_cycles != 3 || bubbles != 3 || STALL_CYCLES !== 4'd3) begin
            n_err++;
            $display("FAIL muldiv_totals: got wait=%0d bubbles=%0d stall=%0d, exp 3 3 3",
                     st_cycles, bubbles, STALL_CYCLES);
        end
    endtask

    task automatic test_dmem_in_wait();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            start = (i == 0);
            dmem  = (i == 2 || i == 3);
            done  = (i >= 2 && i <= 4);
            #3;
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL dmem_wait cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            if (i == 4) begin
                n_vec++;
                if (STATE !== 1'b1) begin
                    n_err++;
                    $display("FAIL dmem_hold_state: got %b, exp 1", STATE);
                end
            end
            tick();
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_idle();
            start = (i == 0);
            done  = (i == 7);
            #3;
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL watchdog cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            // Entered wait at the edge ending cycle 0, so four wait cycles complete by cycle 5.
            if (i == 4 || i == 5) begin
                n_vec++;
                if (MULDIV_ERR !== (i == 5)) begin
                    n_err++;
                    $display("FAIL watchdog_edge cyc%0d: got %b, exp %b", i, MULDIV_ERR, (i == 5));
                end
            end
            tick();
        end
        n_vec++;
        if (MULDIV_ERR !== 1'b1 || STATE !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog_sticky: got err=%b st=%b, exp err=1 st=0", MULDIV_ERR, STATE);
        end
    endtask

    task automatic test_stall_sat();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_idle();
            imem = 1;
            #3;
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL stall_sat cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            tick();
        end
        n_vec++;
        if (STALL_CYCLES !== 4'd15) begin
            n_err++;
            $display("FAIL stall_saturate: got %0d, exp 15", STALL_CYCLES);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_idle();
        start = 1;
        tick();
        set_idle();
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (STATE !== 1'b1 || MULDIV_ERR !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_wait: got st=%b err=%b, exp st=1 err=1", STATE, MULDIV_ERR);
        end
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {7'b1101010, 1'b0, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid_wait: got ctl=%b st=%b err=%b stall=%0d, exp ctl=1101010 st=0 err=0 stall=0",
                     obs, STATE, MULDIV_ERR, STALL_CYCLES);
        end
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            u1       = 1'($urandom_range(0, 1));
            u2       = 1'($urandom_range(0, 1));
            mem_read = 1'($urandom_range(0, 1));
            br       = ($urandom_range(0, 4) == 0);
            start    = ($urandom_range(0, 3) == 0);
            done     = ($urandom_range(0, 3) == 0);
            imem     = ($urandom_range(0, 3) == 0);
            dmem     = ($urandom_range(0, 5) == 0);
            if (i == 300) begin
                RESET = 1'b1;
                #1;
                RESET = 1'b0;
                model_reset();
            end
            #3;
            model_outputs(exp);
            n_vec++;
            if ({obs, STATE, MULDIV_ERR, STALL_CYCLES} !== {exp, m_wait, m_err, m_stall[CW-1:0]}) begin
                n_err++;
                $display("FAIL random cyc%0d: got ctl=%b st=%b err=%b stall=%0d, exp ctl=%b st=%b err=%b stall=%0d",
                         i, obs, STATE, MULDIV_ERR, STALL_CYCLES, exp, m_wait, m_err, m_stall);
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        RESET = 1'b1;
        model_reset();
        #1;
        test_reset();
        test_load_use();
        test_muldiv();
        test_dmem_in_wait();
        test_watchdog();
        test_stall_sat();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
